// File: rtl/wb_csr_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_csr_master_pkg
//   Shared definitions for the Wishbone-to-CSR bridge:
//   - 3-bit FSM state encoding (IDLE, RADDR, RWAIT, WRITE, ACK)
//   - byte-lane select constants for full-word and empty writes
//   - lane_mask(): expands a 4-bit byte select into a 32-bit bit mask
// ---------------------------------------------------------------------------
package wb_csr_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    localparam int         LANES    = 4;
    localparam logic [3:0] SEL_FULL = 4'hF;
    localparam logic [3:0] SEL_NONE = 4'h0;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_csr_master_merge.sv
// ---------------------------------------------------------------------------
// wb_csr_master_merge
//   Combinational 4-lane byte merge used for partial-width writes.
//   Lanes whose select bit is set take the new byte, the others keep the
//   old byte read back from the CSR slave.
// Ports
//   old_i    [31:0]  current register contents (from the CSR slave)
//   new_i    [31:0]  write data latched from the Wishbone cycle
//   sel_i    [3:0]   byte lane enables
//   merged_o [31:0]  read-modify-write result
// ---------------------------------------------------------------------------
module wb_csr_master_merge
    import wb_csr_master_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] merged_o
);

    logic [31:0] mask;

    assign mask     = lane_mask(sel_i);
    assign merged_o = (new_i & mask) | (old_i & ~mask);

endmodule

// File: rtl/wb_csr_master.sv
// ---------------------------------------------------------------------------
// wb_csr_master
//   Wishbone classic slave that acts as the master of a CSR bus. Each single
//   Wishbone cycle becomes one CSR access; partial-width writes become a
//   CSR read followed by a merged CSR write. All outputs are registered.
//
// Ports
//   sys_clk   in   1       clock, rising edge
//   sys_rst   in   1       asynchronous, active-low reset
//   wb_adr_i  in   32      byte address; word address = wb_adr_i[CSR_AW+1:2]
//   wb_dat_i  in   DW      write data
//   wb_sel_i  in   4       byte lane enables
//   wb_stb_i  in   1       strobe
//   wb_cyc_i  in   1       cycle
//   wb_we_i   in   1       1 = write
//   wb_dat_o  out  DW      read data, valid with wb_ack_o
//   wb_ack_o  out  1       one-cycle acknowledge
//   csr_a     out  CSR_AW  CSR word address (holds between accesses)
//   csr_we    out  1       CSR write strobe, one cycle per write
//   csr_do    out  DW      data to the CSR slave
//   csr_di    in   DW      data from the CSR slave, one cycle after csr_a
//
// Configuration
//   WB_CSR_MASTER_POSTED_EN : full-width writes are acked together with the
//   CSR write strobe (one cycle after capture) instead of after it. A new
//   request waits until that write has been issued.
// ---------------------------------------------------------------------------
module wb_csr_master
    import wb_csr_master_pkg::*;
#(
    parameter int CSR_AW = 14,
    parameter int DW     = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    output logic [DW-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [DW-1:0]     csr_do,
    input  logic [DW-1:0]     csr_di
);

    state_e            state_q, state_d;

    // Latched request operands (no reset needed: only read after capture)
    logic [DW-1:0]     dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q,  we_d;

    // Registered outputs
    logic [CSR_AW-1:0] csr_a_q,    csr_a_d;
    logic              csr_we_q,   csr_we_d;
    logic [DW-1:0]     csr_do_q,   csr_do_d;
    logic [DW-1:0]     wb_dat_q,   wb_dat_d;
    logic              wb_ack_q,   wb_ack_d;

    logic [DW-1:0]     merged;

    // Byte-offset bits and address bits above the CSR window are don't-care;
    // the address wraps modulo 2^CSR_AW words.
    logic              unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

    wb_csr_master_merge u_merge (
        .old_i    (csr_di),
        .new_i    (dat_q),
        .sel_i    (sel_q),
        .merged_o (merged)
    );

    always_comb begin
        state_d  = state_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        csr_a_d  = csr_a_q;
        csr_we_d = 1'b0;
        csr_do_d = csr_do_q;
        wb_dat_d = wb_dat_q;
        wb_ack_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    dat_d = wb_dat_i;
                    sel_d = wb_sel_i;
                    we_d  = wb_we_i;
                    if (wb_we_i && (wb_sel_i == SEL_FULL)) begin
                        // Full-word write goes straight to the CSR bus
                        state_d  = ST_WRITE;
                        csr_a_d  = wb_adr_i[CSR_AW+1:2];
                        csr_do_d = wb_dat_i;
                        csr_we_d = 1'b1;
`ifdef WB_CSR_MASTER_POSTED_EN
                        wb_ack_d = 1'b1;
                        wb_dat_d = '0;
`endif
                    end else if (wb_we_i && (wb_sel_i == SEL_NONE)) begin
                        // Nothing to write: acknowledge without touching CSR
                        state_d  = ST_ACK;
                        wb_ack_d = 1'b1;
                        wb_dat_d = '0;
                    end else begin
                        // Reads and partial writes both start with a CSR read
                        state_d = ST_RADDR;
                        csr_a_d = wb_adr_i[CSR_AW+1:2];
                    end
                end
            end
            ST_RADDR: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (we_q) begin
                    state_d  = ST_WRITE;
                    csr_do_d = merged;
                    csr_we_d = 1'b1;
                end else begin
                    state_d  = ST_ACK;
                    wb_dat_d = csr_di;
                    wb_ack_d = wb_cyc_i;
                end
            end
            ST_WRITE: begin
`ifdef WB_CSR_MASTER_POSTED_EN
                if (sel_q == SEL_FULL) begin
                    // Already acknowledged at capture
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_ACK;
                    wb_ack_d = wb_cyc_i;
                    wb_dat_d = '0;
                end
`else
                state_d  = ST_ACK;
                wb_ack_d = wb_cyc_i;
                wb_dat_d = '0;
`endif
            end
            ST_ACK: begin
                // No capture here: keeps a single transaction in flight
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= ST_IDLE;
            csr_a_q  <= '0;
            csr_we_q <= 1'b0;
            csr_do_q <= '0;
            wb_dat_q <= '0;
            wb_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            csr_a_q  <= csr_a_d;
            csr_we_q <= csr_we_d;
            csr_do_q <= csr_do_d;
            wb_dat_q <= wb_dat_d;
            wb_ack_q <= wb_ack_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        dat_q <= dat_d;
        sel_q <= sel_d;
        we_q  <= we_d;
    end

    assign csr_a    = csr_a_q;
    assign csr_we   = csr_we_q;
    assign csr_do   = csr_do_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_ack_o = wb_ack_q;

endmodule

// File: tb/tb_wb_csr_master.sv
// ---------------------------------------------------------------------------
// tb_wb_csr_master
//   Bench for wb_csr_master. A CSR slave model answers csr_di = mem[csr_a]
//   one cycle late and stores csr_do on csr_we. Expected CSR writes are queued
//   when a Wishbone request is driven and matched against the writes the
//   monitor observes. Build with +define+WB_CSR_MASTER_POSTED_EN to exercise
//   the posted-write configuration.
// ---------------------------------------------------------------------------
module tb_wb_csr_master;

    localparam int CSR_AW = 14;

`ifdef WB_CSR_MASTER_POSTED_EN
    localparam int FULL_LAT  = 1;
    localparam int B2B_LAT   = 2;
    localparam int B2B_GAP   = 2;
    localparam int DROP_ACKS = 1;
`else
    localparam int FULL_LAT  = 2;
    localparam int B2B_LAT   = 3;
    localparam int B2B_GAP   = 3;
    localparam int DROP_ACKS = 0;
`endif

    typedef struct {
        logic [CSR_AW-1:0] a;
        logic [31:0]       d;
        int                cyc;
    } wr_t;

    logic              sys_clk  = 1'b0;
    logic              sys_rst  = 1'b1;
    logic [31:0]       wb_adr_i = '0;
    logic [31:0]       wb_dat_i = '0;
    logic [3:0]        wb_sel_i = '0;
    logic              wb_stb_i = 1'b0;
    logic              wb_cyc_i = 1'b0;
    logic              wb_we_i  = 1'b0;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic [CSR_AW-1:0] csr_a;
    logic              csr_we;
    logic [31:0]       csr_do;
    logic [31:0]       csr_di = '0;

    logic [31:0] mem [0:(1<<CSR_AW)-1];
    wr_t         preload_q[$];
    wr_t         exp_wr[$];
    wr_t         seen_wr[$];
    int          wr_rd     = 0;
    int          cycle     = 0;
    int          ack_count = 0;
    int          errors    = 0;
    int          checks    = 0;

    wb_csr_master #(.CSR_AW(CSR_AW), .DW(32)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .csr_di   (csr_di)
    );

    always #5 sys_clk = ~sys_clk;

    // CSR slave model: registered read port, write on csr_we, backdoor preload
    always @(posedge sys_clk) begin
        wr_t p;
        cycle  <= cycle + 1;
        csr_di <= mem[csr_a];
        if (preload_q.size() > 0) begin
            p = preload_q.pop_front();
            mem[p.a] <= p.d;
        end else if (csr_we) begin
            mem[csr_a] <= csr_do;
        end
    end

    // Monitor: records every CSR write and counts acknowledges
    always @(negedge sys_clk) begin
        if (wb_ack_o) ack_count <= ack_count + 1;
        if (csr_we) seen_wr.push_back('{a: csr_a, d: csr_do, cyc: cycle});
    end

    task automatic preload(input logic [CSR_AW-1:0] a, input logic [31:0] d);
        preload_q.push_back('{a: a, d: d, cyc: 0});
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic expect_wr(input logic [CSR_AW-1:0] a, input logic [31:0] d);
        exp_wr.push_back('{a: a, d: d, cyc: 0});
    endtask

    // Called just after a negedge; returns at the negedge where ack is seen.
    // lat = number of rising edges from the request until ack is sampled,
    // 0 if no ack arrived within the budget.
    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we,
                           output logic [31:0] rd, output int lat);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        lat = 0;
        rd  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (wb_ack_o) begin
                lat = k;
                rd  = wb_dat_o;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        checks++;
        if ({csr_a, csr_we, csr_do, wb_dat_o, wb_ack_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h we=%b do=%h dat=%h ack=%b, want all 0",
                     csr_a, csr_we, csr_do, wb_dat_o, wb_ack_o);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({csr_we, wb_ack_o, csr_a} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got we=%b ack=%b a=%h, want 0 0 0", csr_we, wb_ack_o, csr_a);
        end
    endtask

    task automatic test_full_write;
        logic [31:0] rd;
        int          lat;
        wr_t         e, s;
        expect_wr(14'h004, 32'h0000_0001);
        wb_xfer(32'h10, 32'h0000_0001, 4'hF, 1'b1, rd, lat);
        checks++;
        if (lat !== FULL_LAT) begin
            errors++; $display("FAIL full_write_latency: got %0d, want %0d", lat, FULL_LAT);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL full_write_dat_o: got %h, want 00000000", rd);
        end
        @(negedge sys_clk);
        checks++;
        if (wb_ack_o !== 1'b0) begin
            errors++; $display("FAIL full_write_ack_width: ack still %b, want 0", wb_ack_o);
        end
        repeat (2) @(negedge sys_clk);
        checks++;
        if (csr_a !== 14'h004) begin
            errors++; $display("FAIL full_write_csr_a_hold: got %h, want 004", csr_a);
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_rd >= seen_wr.size()) begin
                errors++; $display("FAIL full_write_csr: got no write, want a=%h d=%h", e.a, e.d);
            end else begin
                s = seen_wr[wr_rd]; wr_rd++;
                if (s.a !== e.a || s.d !== e.d) begin
                    errors++; $display("FAIL full_write_csr: got a=%h d=%h, want a=%h d=%h", s.a, s.d, e.a, e.d);
                end
            end
        end
        checks++;
        if (seen_wr.size() != wr_rd) begin
            errors++; $display("FAIL full_write_extra_we: got %0d writes, want %0d", seen_wr.size(), wr_rd);
        end
        wr_rd = seen_wr.size();
    endtask

    task automatic test_read;
        logic [31:0] rd;
        int          lat;
        logic [31:0] addrs [2];
        logic [31:0] vals  [2];
        addrs[0] = 32'h0000_0010; vals[0] = 32'hA5A5_A5A5;
        addrs[1] = 32'hFFFF_FFFF; vals[1] = 32'h0F0F_1234;
        for (int i = 0; i < 2; i++) begin
            preload(addrs[i][CSR_AW+1:2], vals[i]);
            wb_xfer(addrs[i], 32'h0, 4'hF, 1'b0, rd, lat);
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL read%0d_latency: got %0d, want 3", i, lat);
            end
            checks++;
            if (rd !== vals[i]) begin
                errors++; $display("FAIL read%0d_data: got %h, want %h", i, rd, vals[i]);
            end
            @(negedge sys_clk);
        end
        checks++;
        if (seen_wr.size() != wr_rd) begin
            errors++; $display("FAIL read_no_we: got %0d writes, want %0d", seen_wr.size(), wr_rd);
        end
        wr_rd = seen_wr.size();
    endtask

    task automatic test_partial_write;
        logic [31:0] rd;
        int          lat;
        wr_t         e, s;
        // lanes 0 and 2 replaced
        preload(14'h004, 32'h1122_3344);
        expect_wr(14'h004, 32'h11BB_33DD);
        wb_xfer(32'h10, 32'hAABB_CCDD, 4'b0101, 1'b1, rd, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL partial0_latency: got %0d, want 4", lat);
        end
        @(negedge sys_clk);
        // lanes 1 and 3, top of the address window with junk upper/low bits
        preload(14'h3FFF, 32'hCAFE_F00D);
        expect_wr(14'h3FFF, 32'h12FE_560D);
        wb_xfer(32'h0001_FFFE, 32'h1234_5678, 4'b1010, 1'b1, rd, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL partial1_latency: got %0d, want 4", lat);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL partial1_dat_o: got %h, want 00000000", rd);
        end
        repeat (2) @(negedge sys_clk);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_rd >= seen_wr.size()) begin
                errors++; $display("FAIL partial_csr: got no write, want a=%h d=%h", e.a, e.d);
            end else begin
                s = seen_wr[wr_rd]; wr_rd++;
                if (s.a !== e.a || s.d !== e.d) begin
                    errors++; $display("FAIL partial_csr: got a=%h d=%h, want a=%h d=%h", s.a, s.d, e.a, e.d);
                end
            end
        end
        checks++;
        if (seen_wr.size() != wr_rd) begin
            errors++; $display("FAIL partial_extra_we: got %0d writes, want %0d", seen_wr.size(), wr_rd);
        end
        wr_rd = seen_wr.size();
    endtask

    task automatic test_sel_zero_and_cyc_drop;
        logic [31:0]       rd;
        int                lat;
        int                acks0;
        logic [CSR_AW-1:0] a_before;
        wr_t               e, s;
        a_before = csr_a;
        wb_xfer(32'h40, 32'hFFFF_FFFF, 4'h0, 1'b1, rd, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL sel0_latency: got %0d, want 1", lat);
        end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (seen_wr.size() != wr_rd || csr_a !== a_before) begin
            errors++; $display("FAIL sel0_no_csr: got writes=%0d a=%h, want writes=%0d a=%h",
                               seen_wr.size(), csr_a, wr_rd, a_before);
        end
        // master abandons a full write one cycle after the strobe
        acks0 = ack_count;
        expect_wr(14'h008, 32'hDEAD_BEEF);
        wb_adr_i = 32'h20; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;   wb_cyc_i = 1'b1;          wb_stb_i = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (6) @(negedge sys_clk);
        checks++;
        if (ack_count - acks0 !== DROP_ACKS) begin
            errors++; $display("FAIL cyc_drop_ack: got %0d acks, want %0d", ack_count - acks0, DROP_ACKS);
        end
        checks++;
        if (mem[8] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL cyc_drop_mem: got %h, want deadbeef", mem[8]);
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_rd >= seen_wr.size()) begin
                errors++; $display("FAIL cyc_drop_csr: got no write, want a=%h d=%h", e.a, e.d);
            end else begin
                s = seen_wr[wr_rd]; wr_rd++;
                if (s.a !== e.a || s.d !== e.d) begin
                    errors++; $display("FAIL cyc_drop_csr: got a=%h d=%h, want a=%h d=%h", s.a, s.d, e.a, e.d);
                end
            end
        end
        checks++;
        if (seen_wr.size() != wr_rd) begin
            errors++; $display("FAIL cyc_drop_extra_we: got %0d writes, want %0d", seen_wr.size(), wr_rd);
        end
        wr_rd = seen_wr.size();
    endtask

    task automatic test_reset_mid_rmw;
        logic [31:0] rd;
        int          lat;
        wb_xfer(32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        checks++;
        if (rd !== 32'h11BB_33DD || lat !== 3) begin
            errors++; $display("FAIL pre_reset_read: got %h lat %0d, want 11bb33dd lat 3", rd, lat);
        end
        @(negedge sys_clk);
        wb_adr_i = 32'h10; wb_dat_i = 32'h0000_00FF; wb_sel_i = 4'b0001;
        wb_we_i  = 1'b1;   wb_cyc_i = 1'b1;          wb_stb_i = 1'b1;
        @(posedge sys_clk);          // captured, RADDR
        @(posedge sys_clk);          // RWAIT
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        checks++;
        if ({csr_a, csr_we, csr_do, wb_dat_o, wb_ack_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got a=%h we=%b do=%h dat=%h ack=%b, want all 0",
                     csr_a, csr_we, csr_do, wb_dat_o, wb_ack_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (4) @(negedge sys_clk);
        checks++;
        if (seen_wr.size() != wr_rd) begin
            errors++; $display("FAIL mid_reset_no_we: got %0d writes, want %0d", seen_wr.size(), wr_rd);
        end
        wr_rd = seen_wr.size();
        wb_xfer(32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        checks++;
        if (rd !== 32'h11BB_33DD || lat !== 3) begin
            errors++; $display("FAIL post_reset_read: got %h lat %0d, want 11bb33dd lat 3", rd, lat);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int          lat0, lat1, idx, gap;
        wr_t         e, s;
        idx = wr_rd;
        expect_wr(14'h00C, 32'h0101_0101);
        expect_wr(14'h00D, 32'h0202_0202);
        wb_xfer(32'h30, 32'h0101_0101, 4'hF, 1'b1, rd, lat0);
        wb_xfer(32'h34, 32'h0202_0202, 4'hF, 1'b1, rd, lat1);
        checks++;
        if (lat0 !== FULL_LAT || lat1 !== B2B_LAT) begin
            errors++; $display("FAIL b2b_latency: got %0d/%0d, want %0d/%0d", lat0, lat1, FULL_LAT, B2B_LAT);
        end
        repeat (3) @(negedge sys_clk);
        gap = (seen_wr.size() >= idx + 2) ? seen_wr[idx+1].cyc - seen_wr[idx].cyc : -1;
        checks++;
        if (gap !== B2B_GAP) begin
            errors++; $display("FAIL b2b_we_gap: got %0d cycles, want %0d", gap, B2B_GAP);
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_rd >= seen_wr.size()) begin
                errors++; $display("FAIL b2b_csr: got no write, want a=%h d=%h", e.a, e.d);
            end else begin
                s = seen_wr[wr_rd]; wr_rd++;
                if (s.a !== e.a || s.d !== e.d) begin
                    errors++; $display("FAIL b2b_csr: got a=%h d=%h, want a=%h d=%h", s.a, s.d, e.a, e.d);
                end
            end
        end
        checks++;
        if (seen_wr.size() != wr_rd) begin
            errors++; $display("FAIL b2b_extra_we: got %0d writes, want %0d", seen_wr.size(), wr_rd);
        end
        wr_rd = seen_wr.size();
    endtask

    initial begin
        #3;
        test_reset;
        test_full_write;
        test_read;
        test_partial_write;
        test_sel_zero_and_cyc_drop;
        test_reset_mid_rmw;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
